// File: rtl/calculator_core_if.sv
// Bus between the operand source and the calculator_core result side.
// Optional macro: CALC_DIV0_COUNT_EN adds the div0_count signal.
interface calculator_core_if;
    logic [1:0]  func_in;
    logic [7:0]  A_in;
    logic [7:0]  B_in;
    logic        valid_in;
    logic [15:0] out;
    logic        valid_out;
    logic        div0_out;
`ifdef CALC_DIV0_COUNT_EN
    logic [15:0] div0_count;

    modport master (
        output func_in, A_in, B_in, valid_in,
        input  out, valid_out, div0_out, div0_count
    );
    modport slave (
        input  func_in, A_in, B_in, valid_in,
        output out, valid_out, div0_out, div0_count
    );
`else
    modport master (
        output func_in, A_in, B_in, valid_in,
        input  out, valid_out, div0_out
    );
    modport slave (
        input  func_in, A_in, B_in, valid_in,
        output out, valid_out, div0_out
    );
`endif
endinterface

// File: rtl/calculator_core.sv
// Fixed-latency signed 8-bit calculator: add, sub, mul, div with a 16-bit result.
// Stage 1 computes from the raw inputs; the remaining stages only delay.
// Optional macro: CALC_DIV0_COUNT_EN adds a saturating count of valid div-by-zero results.
module calculator_core #(
    parameter int unsigned LATENCY_BLOCK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    calculator_core_if.slave  bus
);

    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;
    logic signed [15:0] b_div;
    logic        [15:0] calc_res;
    logic               calc_div0;

    logic [15:0] res_d   [LATENCY_BLOCK];
    logic [15:0] res_q   [LATENCY_BLOCK];
    logic        valid_d [LATENCY_BLOCK];
    logic        valid_q [LATENCY_BLOCK];
    logic        div0_d  [LATENCY_BLOCK];
    logic        div0_q  [LATENCY_BLOCK];

    // Stage-1 arithmetic on sign-extended operands; 16-bit division keeps -128/-1 exact.
    always_comb begin
        a_ext     = {{8{bus.A_in[7]}}, bus.A_in};
        b_ext     = {{8{bus.B_in[7]}}, bus.B_in};
        b_div     = (bus.B_in == 8'd0) ? 16'sd1 : b_ext;
        calc_res  = '0;
        calc_div0 = 1'b0;
        unique case (bus.func_in)
            2'b00: calc_res = a_ext + b_ext;
            2'b01: calc_res = a_ext - b_ext;
            2'b10: calc_res = a_ext * b_ext;
            default: begin
                if (bus.B_in == 8'd0) begin
                    calc_div0 = 1'b1;
                    calc_res  = bus.A_in[7] ? 16'h8000 : 16'h7FFF;
                end else begin
                    calc_res = a_ext / b_div;
                end
            end
        endcase
    end

    // Next-state for the pipeline: stage 0 loads the new result, later stages shift.
    always_comb begin
        res_d[0]   = calc_res;
        valid_d[0] = bus.valid_in;
        div0_d[0]  = calc_div0;
        for (int unsigned i = 1; i < LATENCY_BLOCK; i++) begin
            res_d[i]   = res_q[i-1];
            valid_d[i] = valid_q[i-1];
            div0_d[i]  = div0_q[i-1];
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight results are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY_BLOCK; i++) begin
                res_q[i]   <= '0;
                valid_q[i] <= 1'b0;
                div0_q[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY_BLOCK; i++) begin
                res_q[i]   <= res_d[i];
                valid_q[i] <= valid_d[i];
                div0_q[i]  <= div0_d[i];
            end
        end
    end

    assign bus.out       = res_q[LATENCY_BLOCK-1];
    assign bus.valid_out = valid_q[LATENCY_BLOCK-1];
    assign bus.div0_out  = div0_q[LATENCY_BLOCK-1];

`ifdef CALC_DIV0_COUNT_EN
    logic [15:0] div0_count_d;
    logic [15:0] div0_count_q;

    // Count valid div-by-zero results seen on the last stage, saturating at all-ones.
    always_comb begin
        div0_count_d = div0_count_q;
        if (valid_q[LATENCY_BLOCK-1] && div0_q[LATENCY_BLOCK-1] && (div0_count_q != '1))
            div0_count_d = div0_count_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_count_q <= '0;
        else        div0_count_q <= div0_count_d;
    end

    assign bus.div0_count = div0_count_q;
`endif

endmodule

// File: tb/tb_calculator_core.sv
// Scoreboard bench for calculator_core: expected results are queued at each sampling
// edge and checked by an independent monitor on the falling edge.
module tb_calculator_core;

    localparam int unsigned LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calculator_core_if bus_if ();

    calculator_core #(.LATENCY_BLOCK(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic        v;
        logic [15:0] r;
        logic        d;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    // Reference: plain integer arithmetic on the signed operand values.
    function automatic exp_t model(input logic v, input logic [1:0] f,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   r;
        ai  = int'($signed(a));
        bi  = int'($signed(b));
        e.v = v;
        e.d = 1'b0;
        case (f)
            2'd0: r = ai + bi;
            2'd1: r = ai - bi;
            2'd2: r = ai * bi;
            default: begin
                if (bi == 0) begin
                    e.d = 1'b1;
                    r   = (ai < 0) ? -32768 : 32767;
                end else begin
                    r = ai / bi;
                end
            end
        endcase
        e.r = r[15:0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected response captured on every sampling edge outside reset.
    always @(posedge clk) begin
        if (rst_n)
            sb.push_back(model(bus_if.valid_in, bus_if.func_in, bus_if.A_in, bus_if.B_in));
    end

    // Monitor: the pipeline is full after LAT samples; before that outputs must be zero.
    always @(negedge clk) begin
        exp_t e;
        int   sat;
        e.v = 1'b0;
        e.r = '0;
        e.d = 1'b0;
        if (rst_n && sb.size() >= LAT)
            e = sb.pop_front();
        chk("out", bus_if.out, e.r);
        chk("valid_out", {15'd0, bus_if.valid_out}, {15'd0, e.v});
        chk("div0_out", {15'd0, bus_if.div0_out}, {15'd0, e.d});
`ifdef CALC_DIV0_COUNT_EN
        sat = (exp_cnt > 65535) ? 65535 : exp_cnt;
        chk("div0_count", bus_if.div0_count, sat[15:0]);
        if (rst_n && e.v && e.d)
            exp_cnt++;
`else
        sat = 0;
`endif
    end

    task automatic drive(input logic v, input logic [1:0] f, input int a, input int b);
        @(negedge clk);
        bus_if.valid_in = v;
        bus_if.func_in  = f;
        bus_if.A_in     = a[7:0];
        bus_if.B_in     = b[7:0];
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        chk("reset_out", bus_if.out, 16'd0);
        chk("reset_valid", {15'd0, bus_if.valid_out}, 16'd0);
        chk("reset_div0", {15'd0, bus_if.div0_out}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] f;
        int         a;
        int         b;
    } stim_t;

    stim_t dir[] = '{
        '{1'b1, 2'd0,  100,  -50},   // 50
        '{1'b1, 2'd1,  100,  -50},   // 150
        '{1'b1, 2'd2, -128, -128},   // 16384
        '{1'b1, 2'd3,   -7,    2},   // -3
        '{1'b1, 2'd3, -128,   -1},   // 128
        '{1'b1, 2'd3,  127,    1},   // 127
        '{1'b1, 2'd3,    5,    0},   // 32767, div0
        '{1'b1, 2'd3,   -1,    0},   // -32768, div0
        '{1'b1, 2'd3,    0,    0},   // 32767, div0
        '{1'b0, 2'd3,    3,    0},   // div0 but not valid
        '{1'b1, 2'd0,    9,    0},   // 9, no div0
        '{1'b1, 2'd0,   11,   22},   // valid pattern 1,0,1,1
        '{1'b0, 2'd1,   11,   22},
        '{1'b1, 2'd2,   -3,    7},
        '{1'b1, 2'd1,  -128, 127}
    };

    initial begin
        bus_if.valid_in = 1'b0;
        bus_if.func_in  = 2'd0;
        bus_if.A_in     = 8'd0;
        bus_if.B_in     = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset with an add in flight.
        drive(1'b1, 2'd0, 5, 3);
        drive(1'b1, 2'd0, 5, 3);
        mid_reset();

        foreach (dir[i]) drive(dir[i].v, dir[i].f, dir[i].a, dir[i].b);
        repeat (LAT + 2) drive(1'b0, 2'd0, 0, 0);

`ifdef CALC_DIV0_COUNT_EN
        chk("div0_count_three", bus_if.div0_count, 16'd3);
        mid_reset();
        repeat (65540) drive(1'b1, 2'd3, 1, 0);
        repeat (LAT + 2) drive(1'b0, 2'd0, 0, 0);
        chk("div0_count_sat", bus_if.div0_count, 16'hFFFF);
        mid_reset();
`endif

        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255)) - 128;
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, b);
            if (i == 150) mid_reset();
        end
        repeat (LAT + 2) drive(1'b0, 2'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
